// File: rtl/simd_vector_unit.sv
// LANES-wide integer vector unit: loads data_size operand pairs into a local
// buffer, then streams one result vector per entry through a valid/ready stage.
module simd_vector_unit #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_instruction,
  input  logic [2:0]                instruction,
  input  logic [ADDR_W:0]           data_size,
  input  logic                      valid_data,
  output logic                      data_ready,
  input  logic [LANES*LANE_W-1:0]   data_in_opa,
  input  logic [LANES*LANE_W-1:0]   data_in_opb,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   out_result,
  output logic [LANES*LANE_W-1:0]   out_extra,
  output logic [LANES-1:0]          out_zero,
  output logic [ADDR_W-1:0]         out_index,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  localparam int unsigned VEC_W = LANES * LANE_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, FLUSH} state_t;

  state_t               state;
  logic [2:0]           op_q;
  logic [CNT_W-1:0]     size_q;
  logic [CNT_W-1:0]     wr_cnt;
  logic [CNT_W-1:0]     rd_cnt;
  logic [ADDR_W-1:0]    wr_ptr;
  logic [ADDR_W-1:0]    rd_ptr;

  logic [VEC_W-1:0]     mem_a [DEPTH];
  logic [VEC_W-1:0]     mem_b [DEPTH];

  logic                 wr_en_c;
  logic [VEC_W-1:0]     rd_a_c;
  logic [VEC_W-1:0]     rd_b_c;
  logic [VEC_W-1:0]     res_c;
  logic [VEC_W-1:0]     ext_c;
  logic [LANES-1:0]     zero_c;
  logic [LANE_W-1:0]    la_c;
  logic [LANE_W-1:0]    lb_c;
  logic [LANE_W-1:0]    lr_c;
  logic [LANE_W-1:0]    le_c;
  logic [LANE_W:0]      sum_c;
  logic [2*LANE_W-1:0]  prod_c;

  assign wr_en_c = (state == LOAD) && data_ready && valid_data;
  assign rd_a_c  = mem_a[rd_ptr];
  assign rd_b_c  = mem_b[rd_ptr];

  // Operand buffer; contents intentionally survive reset and later instructions
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_a[wr_ptr] <= data_in_opa;
      mem_b[wr_ptr] <= data_in_opb;
    end
  end

  // Per-lane datapath for the entry currently addressed by rd_ptr
  always_comb begin
    res_c  = '0;
    ext_c  = '0;
    zero_c = '0;
    la_c   = '0;
    lb_c   = '0;
    lr_c   = '0;
    le_c   = '0;
    sum_c  = '0;
    prod_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      la_c   = rd_a_c[(int'(LANES) - i) * int'(LANE_W) - 1 -: LANE_W];
      lb_c   = rd_b_c[(int'(LANES) - i) * int'(LANE_W) - 1 -: LANE_W];
      sum_c  = {1'b0, la_c} + {1'b0, lb_c};
      prod_c = (2 * LANE_W)'(la_c) * (2 * LANE_W)'(lb_c);
      lr_c   = '0;
      le_c   = '0;
      case (op_q)
        3'b000: begin
          lr_c = sum_c[LANE_W-1:0];
          le_c = LANE_W'(sum_c[LANE_W]);
        end
        3'b001: begin
          lr_c = la_c - lb_c;
          le_c = LANE_W'(la_c < lb_c);
        end
        3'b010: lr_c = la_c & lb_c;
        3'b011: lr_c = la_c | lb_c;
        3'b100: lr_c = la_c ^ lb_c;
        3'b101: begin
          lr_c = prod_c[LANE_W-1:0];
          le_c = prod_c[2*LANE_W-1:LANE_W];
        end
        3'b110: lr_c = ($signed(la_c) < $signed(lb_c)) ? la_c : lb_c;
        default: lr_c = ($signed(la_c) > $signed(lb_c)) ? la_c : lb_c;
      endcase
      res_c[(int'(LANES) - i) * int'(LANE_W) - 1 -: LANE_W] = lr_c;
      ext_c[(int'(LANES) - i) * int'(LANE_W) - 1 -: LANE_W] = le_c;
      zero_c[int'(LANES) - 1 - i] = (lr_c == '0);
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= '0;
      size_q     <= '0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_ready <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_extra  <= '0;
      out_zero   <= '0;
      out_index  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_instruction) begin
            op_q   <= instruction;
            size_q <= data_size;
            if ((data_size == '0) || (data_size > CNT_W'(DEPTH))) begin
              error <= 1'b1;
            end else begin
              state      <= LOAD;
              busy       <= 1'b1;
              data_ready <= 1'b1;
              wr_ptr     <= '0;
              rd_ptr     <= '0;
              wr_cnt     <= '0;
              rd_cnt     <= '0;
            end
          end
        end
        LOAD: begin
          if (wr_en_c) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            wr_cnt <= wr_cnt + CNT_W'(1);
            if ((wr_cnt + CNT_W'(1)) == size_q) begin
              data_ready <= 1'b0;
              state      <= EXEC;
            end
          end
        end
        EXEC: begin
          // Output register advances when empty or when its vector is taken
          if (!out_valid || out_ready) begin
            if (rd_cnt != size_q) begin
              out_result <= res_c;
              out_extra  <= ext_c;
              out_zero   <= zero_c;
              out_index  <= rd_ptr;
              out_valid  <= 1'b1;
              rd_ptr     <= rd_ptr + ADDR_W'(1);
              rd_cnt     <= rd_cnt + CNT_W'(1);
            end else if (out_valid) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= FLUSH;
            end
          end
        end
        FLUSH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_vector_unit.sv
// Scoreboard bench for simd_vector_unit: stimulus pushes expected vectors,
// a negedge monitor compares every presented result against the queue head.
module tb_simd_vector_unit;

  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_instruction;
  logic [2:0]   instruction;
  logic [4:0]   data_size;
  logic         valid_data;
  logic         data_ready;
  logic [127:0] data_in_opa;
  logic [127:0] data_in_opb;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_result;
  logic [127:0] out_extra;
  logic [3:0]   out_zero;
  logic [3:0]   out_index;
  logic         busy;
  logic         done;
  logic         error;

  typedef struct {
    logic [127:0] res;
    logic [127:0] ext;
    logic [3:0]   zero;
    logic [3:0]   idx;
    bit           last;
  } exp_t;

  exp_t         sb[$];
  int           checks   = 0;
  int           failures = 0;
  bit           exp_done = 1'b0;
  logic [127:0] va [16];
  logic [127:0] vb [16];

  simd_vector_unit #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .valid_instruction(valid_instruction),
    .instruction(instruction), .data_size(data_size), .valid_data(valid_data),
    .data_ready(data_ready), .data_in_opa(data_in_opa), .data_in_opb(data_in_opb),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_extra(out_extra), .out_zero(out_zero), .out_index(out_index),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: each lane computed from the opcode rules with plain arithmetic
  function automatic exp_t model(input logic [2:0] op, input logic [127:0] a,
                                 input logic [127:0] b, input int idx, input bit last);
    exp_t e;
    logic [31:0] la, lb, lo, hi;
    longint unsigned s;
    e.res = '0; e.ext = '0; e.zero = '0; e.idx = 4'(idx); e.last = last;
    for (int i = 0; i < LANES; i++) begin
      la = a[127-32*i -: 32];
      lb = b[127-32*i -: 32];
      lo = '0; hi = '0;
      case (op)
        3'd0: begin s = 64'(la) + 64'(lb); lo = s[31:0]; hi = 32'(s[32]); end
        3'd1: begin lo = la - lb; hi = (la < lb) ? 32'd1 : 32'd0; end
        3'd2: lo = la & lb;
        3'd3: lo = la | lb;
        3'd4: lo = la ^ lb;
        3'd5: begin s = 64'(la) * 64'(lb); lo = s[31:0]; hi = s[63:32]; end
        3'd6: lo = ($signed(la) < $signed(lb)) ? la : lb;
        default: lo = ($signed(la) > $signed(lb)) ? la : lb;
      endcase
      e.res[127-32*i -: 32] = lo;
      e.ext[127-32*i -: 32] = hi;
      e.zero[3-i] = (lo == 32'd0);
    end
    return e;
  endfunction

  // Monitor: compare presented output to queue head, pop on handshake, track done
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        if ((done !== exp_done) || exp_done)
          check("done_pulse", 128'(done), 128'(exp_done));
        exp_done = 1'b0;
        if (out_valid === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output index=%0d result=%h expected=none", out_index, out_result);
          end else begin
            e = sb[0];
            check("out_result", out_result, e.res);
            check("out_extra", out_extra, e.ext);
            check("out_zero", 128'(out_zero), 128'(e.zero));
            check("out_index", 128'(out_index), 128'(e.idx));
            if (out_ready === 1'b1) begin
              void'(sb.pop_front());
              if (e.last) exp_done = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic check_cleared(input string tag);
    check({tag, "_data_ready"}, 128'(data_ready), 128'(0));
    check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_done"}, 128'(done), 128'(0));
    check({tag, "_error"}, 128'(error), 128'(0));
    check({tag, "_out_result"}, out_result, 128'(0));
    check({tag, "_out_extra"}, out_extra, 128'(0));
    check({tag, "_out_zero_index"}, 128'({out_zero, out_index}), 128'(0));
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < LANES; i++) begin
        va[k][127-32*i -: 32] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        vb[k][127-32*i -: 32] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      end
    end
  endtask

  task automatic issue(input logic [2:0] op, input int sz);
    valid_instruction = 1'b1;
    instruction       = op;
    data_size         = 5'(sz);
    @(posedge clk); #1;
    valid_instruction = 1'b0;
  endtask

  task automatic load(input logic [2:0] op, input int sz, input bit gaps);
    int k = 0;
    int guard = 0;
    while (k < sz && guard < 200) begin
      valid_data  = gaps ? 1'($urandom_range(0, 2) != 0) : 1'b1;
      data_in_opa = va[k];
      data_in_opb = vb[k];
      if (valid_data) sb.push_back(model(op, va[k], vb[k], k, k == sz - 1));
      @(posedge clk); #1;
      if (valid_data) k++;
      guard++;
    end
    valid_data = 1'b0;
    if (k < sz) begin
      checks++; failures++;
      $display("FAIL load_timeout written=%0d required=%0d", k, sz);
    end
    check("data_ready_after_load", 128'(data_ready), 128'(0));
  endtask

  // mode 0: always ready; 1: random ready; 2: ready low for 3 cycles mid-stream
  task automatic drain(input int sz, input int mode);
    int c = 0;
    bit seen = 1'b0;
    while (!seen && c < 400) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : !(c >= 2 && c < 5);
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
      if (!seen) c++;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL done_timeout cycles=%0d required_done=1", c);
    end else if (mode == 0) begin
      check("stream_latency", 128'(c), 128'(sz + 1));
    end
    check("sb_empty", 128'(sb.size()), 128'(0));
    check("busy_after_done", 128'(busy), 128'(0));
    out_ready = 1'b1;
  endtask

  task automatic run(input logic [2:0] op, input int sz, input bit gaps, input int mode);
    issue(op, sz);
    check("data_ready_in_load", 128'(data_ready), 128'(1));
    check("busy_in_load", 128'(busy), 128'(1));
    load(op, sz, gaps);
    drain(sz, mode);
  endtask

  task automatic bad_size(input int sz);
    issue(3'd0, sz);
    check("error_pulse", 128'(error), 128'(1));
    check("error_busy", 128'(busy), 128'(0));
    check("error_data_ready", 128'(data_ready), 128'(0));
    @(posedge clk); #1;
    check("error_clears", 128'(error), 128'(0));
    check("error_still_idle", 128'(busy), 128'(0));
  endtask

  task automatic pulse_reset();
    sb.delete();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog_timeout time=%0t limit=500000", $time);
    $fatal(1, "bench watchdog expired");
  end

  initial begin : stimulus
    int wait_c;
    reset = 1'b1; valid_instruction = 1'b0; instruction = '0; data_size = '0;
    valid_data = 1'b0; data_in_opa = '0; data_in_opb = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // ADD with carry out of lane 0 and a zero result in that lane
    va[0] = {32'hFFFFFFFF, 32'd5, 32'd5, 32'd5};
    vb[0] = {32'd1, 32'd7, 32'd7, 32'd7};
    run(3'd0, 1, 1'b0, 0);

    // MUL high/low halves, back-to-back entries
    for (int k = 0; k < 2; k++) begin
      va[k] = {4{32'h00010000}};
      vb[k] = {4{32'h00010000}};
    end
    run(3'd5, 2, 1'b0, 0);

    // Signed MIN / MAX
    va[0] = {4{32'hFFFFFFFE}};
    vb[0] = {4{32'd3}};
    run(3'd6, 1, 1'b0, 0);
    run(3'd7, 1, 1'b0, 0);

    // SUB with borrow under mid-stream backpressure
    for (int k = 0; k < 4; k++) begin
      va[k] = {4{32'd2}};
      vb[k] = {4{32'd3}};
    end
    run(3'd1, 4, 1'b0, 2);

    // Rejected sizes
    bad_size(0);
    bad_size(17);

    // Full buffer with input gaps and random backpressure
    fill_random(16);
    run(3'($urandom_range(0, 7)), 16, 1'b1, 1);

    // Random mix of opcodes and sizes
    for (int n = 0; n < 10; n++) begin
      int sz;
      sz = $urandom_range(1, 16);
      fill_random(sz);
      run(3'(n % 8), sz, 1'($urandom_range(0, 1)), $urandom_range(0, 1));
    end

    // Reset during LOAD after two writes
    fill_random(4);
    issue(3'd0, 4);
    valid_data = 1'b1;
    for (int k = 0; k < 2; k++) begin
      data_in_opa = va[k]; data_in_opb = vb[k];
      @(posedge clk); #1;
    end
    valid_data = 1'b0;
    pulse_reset();
    check_cleared("reset_in_load");
    @(posedge clk); #1;
    check("no_done_after_load_reset", 128'(done), 128'(0));

    // Reset during EXEC while a result is held
    out_ready = 1'b0;
    fill_random(3);
    issue(3'd1, 3);
    load(3'd1, 3, 1'b0);
    wait_c = 0;
    while (out_valid !== 1'b1 && wait_c < 20) begin
      @(posedge clk); #1;
      wait_c++;
    end
    check("exec_out_valid_seen", 128'(out_valid), 128'(1));
    pulse_reset();
    check_cleared("reset_in_exec");
    @(posedge clk); #1;
    check("no_done_after_exec_reset", 128'(done), 128'(0));
    out_ready = 1'b1;

    // Unit recovers with a fresh ADD
    fill_random(3);
    run(3'd0, 3, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simd_vector_unit.md
Name: simd_vector_unit

Overview:
- Parametrised successor to the fixed 4-lane, 32-bit SIMD top level.
- LANES-wide integer vector unit with an internal operand buffer of DEPTH vector pairs.
- Accepts one instruction, loads data_size operand pairs, then streams one result vector per entry through a valid/ready output stage, with per-lane zero flags.
- Self-contained: no separate ALU, memory controller or RAM instances are required.

Parameters:
- LANES, 4, number of parallel lanes (>=1).
- LANE_W, 32, width of one lane operand in bits (>=2).
- DEPTH, 16, operand buffer entries (power of two, >=2).
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- valid_instruction  input  1  instruction and data_size valid this cycle.
- instruction  input  3  opcode (see Behaviour).
- data_size  input  ADDR_W+1  number of vector pairs to process, legal range 1..DEPTH.
- valid_data  input  1  data_in_opa/opb valid this cycle.
- data_ready  output  1  unit accepts operand data this cycle.
- data_in_opa  input  LANES*LANE_W  operand A vector.
- data_in_opb  input  LANES*LANE_W  operand B vector.
- out_valid  output  1  result registers hold a valid vector.
- out_ready  input  1  consumer accepts the result this cycle.
- out_result  output  LANES*LANE_W  primary lane results.
- out_extra  output  LANES*LANE_W  secondary lane results.
- out_zero  output  LANES  per-lane flag, 1 when that lane's out_result is zero.
- out_index  output  ADDR_W  buffer entry the current result came from.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last result handshake.
- error  output  1  one-cycle pulse when an instruction is rejected.

Behaviour:
- Lane packing: lane i occupies bits [(LANES-i)*LANE_W-1 -: LANE_W]; lane 0 is the MSBs. Identical packing on all vector ports.
- Reset values: data_ready, out_valid, busy, done, error = 0; out_result, out_extra, out_zero, out_index = 0; write and read pointers = 0; state = IDLE. Reset in any state aborts the operation with no done pulse.
- Opcodes, per lane, a/b unsigned unless stated:
  - 000 ADD: result=a+b mod 2^LANE_W; extra = carry-out in bit 0, other bits 0.
  - 001 SUB: result=a-b; extra bit 0 = borrow (a<b).
  - 010 AND, 011 OR, 100 XOR: extra=0.
  - 101 MUL: full 2*LANE_W product; result = low half, extra = high half.
  - 110 MIN, signed: result = min(a,b); extra=0.
  - 111 MAX, signed: result = max(a,b); extra=0.
- State machine: IDLE, LOAD, EXEC, FLUSH.
- IDLE:
  - On valid_instruction, latch opcode and data_size.
  - If data_size==0 or data_size>DEPTH: pulse error next cycle and stay in IDLE.
  - Otherwise go to LOAD; pointers clear to 0.
- LOAD:
  - data_ready=1.
  - Each cycle with valid_data=1 writes entry wr_ptr and increments it.
  - When the write count reaches data_size, data_ready drops the following cycle and the state goes to EXEC.
  - valid_data with data_ready=0 is ignored.
- EXEC:
  - Output stage is a single register.
  - When out_valid=0, or out_valid=1 and out_ready=1, and entries remain: load results for entry rd_ptr, set out_index=rd_ptr, set out_valid=1, increment rd_ptr.
  - While out_valid=1 and out_ready=0, all outputs hold stable.
  - Back-to-back throughput is one vector per cycle when out_ready is held high.
  - First out_valid rises exactly one cycle after entering EXEC.
- FLUSH:
  - Entered on the handshake of the last entry.
  - out_valid=0, done=1 for exactly that cycle, then IDLE.
- valid_instruction while busy=1 is ignored; no error is raised.
- A new instruction may be accepted in the cycle after done.
- Buffer contents are not cleared between instructions. Only the first data_size entries are read.
- DEPTH boundary: data_size=DEPTH fills every entry. wr_ptr wraps to 0 and is not reused in that run.

Test Plan:
- LANES=4, LANE_W=32. ADD, size 1: lane0 a=0xFFFFFFFF, b=1; others a=5, b=7 -> out_result lane0=0, out_zero=4'b1000, extra lane0=1; other lanes result=12; done one cycle after the handshake.
- MUL, size 2, out_ready=1: a=0x00010000, b=0x00010000 in all lanes -> result=0, extra=1, out_zero=4'b1111; entries 0 and 1 on consecutive cycles, out_index 0 then 1.
- MIN and MAX signed, a=0xFFFFFFFE (-2), b=3 -> MIN=0xFFFFFFFE, MAX=3.
- Backpressure: SUB, size 4, out_ready low for 3 cycles mid-stream -> outputs held stable; all 4 results delivered in order; a=2, b=3 gives result=0xFFFFFFFF, extra=1.
- data_size=0 and data_size=17 -> error pulse, busy stays 0, data_ready stays 0. Size 16 with valid_data gaps -> all 16 results in order.
- Reset asserted in LOAD after 2 writes and again in EXEC with out_valid=1 -> all outputs return to 0 next cycle, no done pulse; a following ADD runs correctly.
